// File: rtl/branch_predictor_pkg.sv
//------------------------------------------------------------------------------
// Module      : branch_predictor_pkg
// Description : Shared branch-type enum, 2-bit counter encodings and the
//               saturating counter update helper for the branch predictor.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package branch_predictor_pkg;

   typedef enum logic [1:0] {
      OP_CC = 2'b00,
      OP_B  = 2'b01,
      OP_BL = 2'b10,
      OP_BX = 2'b11
   } branch_op_e;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      if (taken)
         return (ctr == ST) ? ST : ctr + 2'd1;
      else
         return (ctr == SNT) ? SNT : ctr - 2'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/return_address_stack.sv
//------------------------------------------------------------------------------
// Module      : return_address_stack
// Description : Circular return-address stack; a push when full overwrites
//               the oldest entry, a pop when empty is ignored.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module return_address_stack #(
   parameter int PC_WIDTH  = 16,
   parameter int RAS_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic                flush,
   input  logic [PC_WIDTH-1:0] push_addr,
   output logic [PC_WIDTH-1:0] top_addr,
   output logic                valid
);

   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(RAS_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RAS_DEPTH);

   logic [PC_WIDTH-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    next_ptr;
   logic [PTR_W-1:0]    top_ptr;
   logic [CNT_W-1:0]    count;

   // wr_ptr is the next free slot; the top of stack sits one slot behind it
   assign next_ptr = (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
   assign top_ptr  = (wr_ptr == '0) ? LAST_SLOT : wr_ptr - 1'b1;
   assign valid    = (count != '0);
   assign top_addr = mem[top_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (push) begin
         mem[wr_ptr] <= push_addr;
         wr_ptr      <= next_ptr;
         if (count != FULL_CNT)
            count <= count + 1'b1;
      end else if (pop && valid) begin
         wr_ptr <= top_ptr;
         count  <= count - 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
//------------------------------------------------------------------------------
// Module      : branch_predictor
// Description : 2-bit-counter branch history table with static backward-taken
//               fallback; optional return-address stack for BL/BX enabled by
//               the macro BRANCH_PREDICTOR_RAS_EN.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int PC_WIDTH    = 16,
   parameter int BHT_ENTRIES = 64,
   parameter int RAS_DEPTH   = 4
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                is_branch_i,
   input  logic [1:0]          branch_op_code_i,
   input  logic                sign_bit_i,
   input  logic [PC_WIDTH-1:0] pc_i,
   input  logic                stall_i,
   input  logic                resolve_valid_i,
   input  logic [PC_WIDTH-1:0] resolve_pc_i,
   input  logic                resolve_taken_i,
   input  logic                flush_i,
   output logic                take_branch_o,
   output logic                speculative_o,
   output logic                ras_target_valid_o,
   output logic [PC_WIDTH-1:0] ras_target_o
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   branch_op_e       op;
   logic [IDX_W-1:0] pred_idx;
   logic [IDX_W-1:0] res_idx;
   logic [1:0]       pred_ctr;
   logic [1:0]       bht [BHT_ENTRIES];
   logic             ras_valid;
   logic [PC_WIDTH-1:0] ras_top;
   logic             unused_bits;

   assign op       = branch_op_e'(branch_op_code_i);
   assign pred_idx = pc_i[IDX_W-1:0];
   assign res_idx  = resolve_pc_i[IDX_W-1:0];
   assign pred_ctr = bht[pred_idx];

   // Counters train on resolution even during stalls
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < BHT_ENTRIES; i++)
            bht[i] <= WNT;
      end else if (resolve_valid_i) begin
         bht[res_idx] <= sat_update(bht[res_idx], resolve_taken_i);
      end
   end

`ifdef BRANCH_PREDICTOR_RAS_EN
   logic ras_push;
   logic ras_pop;

   assign ras_push = is_branch_i && (op == OP_BL) && !stall_i;
   assign ras_pop  = is_branch_i && (op == OP_BX) && !stall_i;

   return_address_stack #(
      .PC_WIDTH  (PC_WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk_i),
      .rst       (reset_i),
      .push      (ras_push),
      .pop       (ras_pop),
      .flush     (flush_i),
      .push_addr (pc_i + 1'b1),
      .top_addr  (ras_top),
      .valid     (ras_valid)
   );
`else
   assign ras_valid = 1'b0;
   assign ras_top   = '0;
`endif

   always_comb begin
      take_branch_o      = 1'b0;
      speculative_o      = 1'b0;
      ras_target_valid_o = 1'b0;
      ras_target_o       = '0;
      if (is_branch_i && !reset_i) begin
         case (op)
            OP_CC: begin
               speculative_o = 1'b1;
               // Weak states defer to the static backward-taken rule
               if (pred_ctr == ST || pred_ctr == SNT)
                  take_branch_o = pred_ctr[1];
               else
                  take_branch_o = sign_bit_i;
            end
            OP_B, OP_BL: begin
               take_branch_o = 1'b1;
            end
            default: begin
               speculative_o      = 1'b1;
               take_branch_o      = ras_valid;
               ras_target_valid_o = ras_valid;
               ras_target_o       = ras_valid ? ras_top : '0;
            end
         endcase
      end
   end

   assign unused_bits = ^{pc_i, resolve_pc_i, stall_i, flush_i, ras_top};

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
//------------------------------------------------------------------------------
// Module      : tb_branch_predictor
// Description : Directed plus randomized checks of branch_predictor against a
//               behavioural model (counter array and return-address queue).
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_predictor;

   localparam int PCW   = 16;
   localparam int NBHT  = 64;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            is_branch;
   logic [1:0]      op;
   logic            sign_bit;
   logic [PCW-1:0]  pc;
   logic            stall;
   logic            resolve_valid;
   logic [PCW-1:0]  resolve_pc;
   logic            resolve_taken;
   logic            flush;
   logic            take;
   logic            spec;
   logic            tvalid;
   logic [PCW-1:0]  target;

   int n_vec  = 0;
   int n_fail = 0;

   // Behavioural model: counters as integers 0..3, RAS as a bounded queue
   int cnt [NBHT];
   int ras_q [$];

   branch_predictor #(
      .PC_WIDTH    (PCW),
      .BHT_ENTRIES (NBHT),
      .RAS_DEPTH   (DEPTH)
   ) dut (
      .clk_i              (clk),
      .reset_i            (reset),
      .is_branch_i        (is_branch),
      .branch_op_code_i   (op),
      .sign_bit_i         (sign_bit),
      .pc_i               (pc),
      .stall_i            (stall),
      .resolve_valid_i    (resolve_valid),
      .resolve_pc_i       (resolve_pc),
      .resolve_taken_i    (resolve_taken),
      .flush_i            (flush),
      .take_branch_o      (take),
      .speculative_o      (spec),
      .ras_target_valid_o (tvalid),
      .ras_target_o       (target)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic apply(input logic r, input logic br, input logic [1:0] o, input logic sg,
                        input logic [PCW-1:0] p, input logic st, input logic rv,
                        input logic [PCW-1:0] rp, input logic rt, input logic fl);
      int  e_take, e_spec, e_tv, e_tgt, c, ri;
      bit  ras_en;
`ifdef BRANCH_PREDICTOR_RAS_EN
      ras_en = 1'b1;
`else
      ras_en = 1'b0;
`endif
      reset = r; is_branch = br; op = o; sign_bit = sg; pc = p; stall = st;
      resolve_valid = rv; resolve_pc = rp; resolve_taken = rt; flush = fl;
      @(negedge clk);
      e_take = 0; e_spec = 0; e_tv = 0; e_tgt = 0;
      if (!r && br) begin
         case (o)
            2'b00: begin
               c = cnt[p % NBHT];
               e_spec = 1;
               e_take = (c == 3) ? 1 : (c == 0) ? 0 : int'(sg);
            end
            2'b01, 2'b10: e_take = 1;
            default: begin
               e_spec = 1;
               if (ras_en && ras_q.size() > 0) begin
                  e_take = 1; e_tv = 1; e_tgt = ras_q[$];
               end
            end
         endcase
      end
      check("take", 32'(take), 32'(e_take));
      check("spec", 32'(spec), 32'(e_spec));
      check("tvalid", 32'(tvalid), 32'(e_tv));
      check("target", 32'(target), 32'(e_tgt));
      // Advance the model to the state after the coming rising edge
      if (r) begin
         foreach (cnt[i]) cnt[i] = 1;
         ras_q.delete();
      end else begin
         if (rv) begin
            ri = rp % NBHT;
            cnt[ri] = rt ? ((cnt[ri] < 3) ? cnt[ri] + 1 : 3) : ((cnt[ri] > 0) ? cnt[ri] - 1 : 0);
         end
         if (ras_en) begin
            if (fl) ras_q.delete();
            else if (br && !st && o == 2'b10) begin
               ras_q.push_back((int'(p) + 1) % (1 << PCW));
               if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
            end else if (br && !st && o == 2'b11 && ras_q.size() > 0)
               void'(ras_q.pop_back());
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Shorthands: predict-only and resolve-only vectors
   task automatic pred(input logic [1:0] o, input logic sg, input logic [PCW-1:0] p);
      apply(0, 1, o, sg, p, 0, 0, '0, 0, 0);
   endtask

   task automatic resolve(input logic [PCW-1:0] rp, input logic rt);
      apply(0, 0, 2'b00, 0, '0, 0, 1, rp, rt, 0);
   endtask

   initial begin
      apply(1, 1, 2'b01, 1, 16'h0010, 0, 1, 16'h0010, 1, 1);
      apply(1, 0, 2'b00, 0, '0, 0, 0, '0, 0, 0);
      // Weak counter falls back to the sign bit, then saturates taken
      pred(2'b00, 1, 16'h0010);
      pred(2'b00, 0, 16'h0010);
      resolve(16'h0010, 1);
      resolve(16'h0010, 1);
      pred(2'b00, 0, 16'h0010);
      resolve(16'h0010, 1);
      pred(2'b00, 0, 16'h0010);
      resolve(16'h0010, 0);
      resolve(16'h0010, 0);
      resolve(16'h0010, 0);
      resolve(16'h0010, 0);
      pred(2'b00, 1, 16'h0010);
      // Same-index resolve and predict use the pre-update counter
      resolve(16'h0005, 0);
      apply(0, 1, 2'b00, 1, 16'h0005, 0, 1, 16'h0005, 0, 0);
      pred(2'b00, 1, 16'h0005);
      // Aliased index from the upper PC bits
      resolve(16'h0145, 1);
      pred(2'b00, 0, 16'h0005);
      pred(2'b01, 0, 16'h1234);
      pred(2'b10, 0, 16'h2000);
      // RAS overflow and underflow
      for (int i = 1; i <= 5; i++) pred(2'b10, 0, PCW'(i * 16'h0100));
      for (int i = 0; i < 5; i++) pred(2'b11, 0, 16'h0000);
      pred(2'b10, 0, 16'hFFFF);
      pred(2'b11, 0, 16'h0000);
      apply(0, 1, 2'b10, 0, 16'h0700, 0, 0, '0, 0, 1);
      pred(2'b11, 0, 16'h0000);
      // Stalled push/pop leave the RAS untouched
      pred(2'b10, 0, 16'h0800);
      apply(0, 1, 2'b11, 0, 16'h0000, 1, 0, '0, 0, 0);
      apply(0, 1, 2'b10, 0, 16'h0900, 1, 0, '0, 0, 0);
      pred(2'b11, 0, 16'h0000);
      // Reset overrides a same-cycle resolve
      resolve(16'h0020, 1);
      resolve(16'h0020, 1);
      apply(1, 1, 2'b00, 0, 16'h0020, 0, 1, 16'h0020, 1, 0);
      pred(2'b00, 0, 16'h0020);
      pred(2'b00, 1, 16'h0020);
      for (int n = 0; n < 1500; n++) begin
         apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
               2'($urandom_range(0, 3)), 1'($urandom), PCW'($urandom_range(0, 11) + ($urandom_range(0, 3) << 6)),
               ($urandom_range(0, 4) == 0), 1'($urandom), PCW'($urandom_range(0, 11) + ($urandom_range(0, 3) << 6)),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
